// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and constants for the fetch-PC redirect controller.
package pc_redirect_ctrl_pkg;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Byte distance between consecutive instructions.
  localparam int unsigned PC_STEP = 4;

  // Low PC bits that must be zero for a word-aligned fetch address.
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

  // True when the two low target bits would produce a misaligned fetch.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |(lsb & PC_ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for the branch statistics.
module pc_redirect_ctrl_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: synchronous clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    // NOTE: assign a default first so every path drives cnt_d; no latch is inferred.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// Owns the architectural fetch PC: sequences it through boot, normal fetch,
// stall and redirect, generates IF/ID and ID/EX flush pulses, and keeps
// saturating branch statistics.
module pc_redirect_ctrl
  import pc_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int              FLUSH_CYCLES = 2,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_target_i,
  input  logic             imem_ready_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic             flush_ifid_o,
  output logic             flush_idex_o,
  output logic             misalign_o,
  output logic             err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  // The flush counter only has to hold FLUSH_CYCLES-1.
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [FC_W-1:0] flush_cnt_q, flush_cnt_d;
  logic            misalign_q, misalign_d;
  logic            err_q, err_d;

  logic            run_redirect;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] target_aligned;

  assign run_redirect   = (state_q == ST_RUN) && redirect_i;
  assign pc_inc         = pc_q + XLEN'(PC_STEP);
  assign target_aligned = {redirect_target_i[XLEN-1:2], 2'b00};

  // State, PC, flush counter and status flags; everything returns to boot on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_PC;
      flush_cnt_q <= '0;
      misalign_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      misalign_q  <= misalign_d;
      err_q       <= err_d;
    end
  end

  // Next-state and PC sequencing: redirect beats stall beats memory acceptance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush_cnt_d = flush_cnt_q;
    misalign_d  = 1'b0;
    err_d       = err_q;
    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (redirect_i) begin
          pc_d       = target_aligned;
          misalign_d = is_misaligned(redirect_target_i[1:0]);
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
          end
        end else if (!stall_i && imem_ready_i) begin
          pc_d = pc_inc;
        end
      end
      ST_FLUSH: begin
        // A redirect here is a protocol violation: record it, otherwise ignore it.
        if (redirect_i) begin
          err_d = 1'b1;
        end
        if (imem_ready_i) begin
          pc_d = pc_inc;
        end
        flush_cnt_d = flush_cnt_q - FC_W'(1);
        if (flush_cnt_q == FC_W'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Output decode: flushes are combinational from redirect_i while in RUN.
  always_comb begin
    pc_valid_o   = 1'b0;
    flush_ifid_o = 1'b0;
    flush_idex_o = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        pc_valid_o   = 1'b1;
        flush_ifid_o = redirect_i;
        flush_idex_o = redirect_i;
      end
      ST_FLUSH: begin
        pc_valid_o   = 1'b1;
        flush_ifid_o = 1'b1;
      end
      default: begin
        pc_valid_o = 1'b0;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
  assign err_o      = err_q;

  // Resolved conditional branches; jumps and non-RUN cycles do not count.
  pc_redirect_ctrl_sat_counter #(.W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((state_q == ST_RUN) && branch_i),
    .clear (1'b0),
    .cnt_o (branch_cnt_o)
  );

  // Taken conditional branches.
  pc_redirect_ctrl_sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run_redirect && branch_i),
    .clear (1'b0),
    .cnt_o (taken_cnt_o)
  );

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: the driver pushes a hand-computed
// expectation for every cycle it drives, the monitor pops and compares on the
// falling edge.
module tb_pc_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  typedef struct {
    logic [31:0] pc;
    logic        v;
    logic        fi;
    logic        fe;
    logic        mis;
    logic        err;
    logic [1:0]  bc;
    logic [1:0]  tc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall_i = 1'b0;
  logic             branch_i = 1'b0;
  logic             redirect_i = 1'b0;
  logic [XLEN-1:0]  redirect_target_i = '0;
  logic             imem_ready_i = 1'b0;
  logic [XLEN-1:0]  pc_o;
  logic             pc_valid_o;
  logic             flush_ifid_o;
  logic             flush_idex_o;
  logic             misalign_o;
  logic             err_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] taken_cnt_o;

  int   errors = 0;
  int   checks = 0;
  int   cycle_no = 0;
  exp_t exp_q[$];

  pc_redirect_ctrl #(
    .XLEN         (XLEN),
    .RESET_PC     (32'h0000_0000),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .branch_i          (branch_i),
    .redirect_i        (redirect_i),
    .redirect_target_i (redirect_target_i),
    .imem_ready_i      (imem_ready_i),
    .pc_o              (pc_o),
    .pc_valid_o        (pc_valid_o),
    .flush_ifid_o      (flush_ifid_o),
    .flush_idex_o      (flush_idex_o),
    .misalign_o        (misalign_o),
    .err_o             (err_o),
    .branch_cnt_o      (branch_cnt_o),
    .taken_cnt_o       (taken_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cycle_no, act, req);
    end
  endtask

  function automatic exp_t e(input logic [31:0] pc, input logic v, input logic fi,
                             input logic fe, input logic mis, input logic err,
                             input logic [1:0] bc, input logic [1:0] tc);
    exp_t x;
    x.pc = pc; x.v = v; x.fi = fi; x.fe = fe;
    x.mis = mis; x.err = err; x.bc = bc; x.tc = tc;
    return x;
  endfunction

  // Drive one cycle's inputs just after the rising edge and queue what the
  // outputs must show during that cycle; optionally pull reset mid-cycle.
  task automatic cyc(input logic rst, input logic st, input logic br, input logic rd,
                     input logic [31:0] tgt, input logic rdy, input exp_t ex,
                     input logic async_rst);
    @(posedge clk);
    #1;
    rst_n             = rst;
    stall_i           = st;
    branch_i          = br;
    redirect_i        = rd;
    redirect_target_i = tgt;
    imem_ready_i      = rdy;
    exp_q.push_back(ex);
    if (async_rst) begin
      #2 rst_n = 1'b0;
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t x;
      x = exp_q.pop_front();
      cycle_no++;
      check("pc_o",         pc_o,         x.pc);
      check("pc_valid_o",   32'(pc_valid_o),   32'(x.v));
      check("flush_ifid_o", 32'(flush_ifid_o), 32'(x.fi));
      check("flush_idex_o", 32'(flush_idex_o), 32'(x.fe));
      check("misalign_o",   32'(misalign_o),   32'(x.mis));
      check("err_o",        32'(err_o),        32'(x.err));
      check("branch_cnt_o", 32'(branch_cnt_o), 32'(x.bc));
      check("taken_cnt_o",  32'(taken_cnt_o),  32'(x.tc));
    end
  end

  initial begin
    // Reset held for three cycles; inputs are ignored.
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 32'h0, 1, e(32'h0, 0, 0, 0, 0, 0, 0, 0), 0);
    // Release: one BOOT cycle with no request, then sequential fetch.
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h0,  0, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h0,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h4,  1, 0, 0, 0, 0, 0, 0), 0);
    // Stall for two cycles, then back-pressure for two: PC holds at 8.
    cyc(1, 1, 0, 0, 32'h0, 1, e(32'h8,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 1, 0, 0, 32'h0, 1, e(32'h8,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 0, e(32'h8,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 0, e(32'h8,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h8,  1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'hC,  1, 0, 0, 0, 0, 0, 0), 0);
    // Taken branch under stall at 0x10: both flushes now, IF/ID only next cycle.
    cyc(1, 1, 1, 1, 32'h40, 1, e(32'h10, 1, 1, 1, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0,  0, e(32'h40, 1, 1, 0, 0, 0, 1, 1), 0);
    cyc(1, 0, 0, 0, 32'h0,  1, e(32'h40, 1, 0, 0, 0, 0, 1, 1), 0);
    // Not-taken branch counts only in branch_cnt.
    cyc(1, 0, 1, 0, 32'h0,  1, e(32'h44, 1, 0, 0, 0, 0, 1, 1), 0);
    // Misaligned jump: aligned PC, one-cycle misalign pulse, no stats.
    cyc(1, 0, 0, 1, 32'h103, 1, e(32'h48,  1, 1, 1, 0, 0, 2, 1), 0);
    // Redirect during FLUSH is ignored apart from setting err (branch_i too).
    cyc(1, 0, 1, 1, 32'h200, 1, e(32'h100, 1, 1, 0, 1, 0, 2, 1), 0);
    cyc(1, 0, 0, 0, 32'h0,   0, e(32'h104, 1, 0, 0, 0, 1, 2, 1), 0);
    // Branch to the top word, then wrap to zero on acceptance.
    cyc(1, 0, 1, 1, 32'hFFFF_FFFC, 0, e(32'h104,       1, 1, 1, 0, 1, 2, 1), 0);
    cyc(1, 0, 0, 0, 32'h0,         1, e(32'hFFFF_FFFC, 1, 1, 0, 0, 1, 3, 2), 0);
    cyc(1, 0, 0, 0, 32'h0,         0, e(32'h0,         1, 0, 0, 0, 1, 3, 2), 0);
    // More taken branches: both 2-bit counters saturate at 3.
    cyc(1, 0, 1, 1, 32'h20, 0, e(32'h0,  1, 1, 1, 0, 1, 3, 2), 0);
    cyc(1, 0, 0, 0, 32'h0,  0, e(32'h20, 1, 1, 0, 0, 1, 3, 3), 0);
    cyc(1, 0, 1, 1, 32'h30, 0, e(32'h20, 1, 1, 1, 0, 1, 3, 3), 0);
    cyc(1, 0, 0, 0, 32'h0,  0, e(32'h30, 1, 1, 0, 0, 1, 3, 3), 0);
    cyc(1, 0, 1, 1, 32'h50, 0, e(32'h30, 1, 1, 1, 0, 1, 3, 3), 0);
    // Reset asserted asynchronously inside the following FLUSH cycle.
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h0, 0, 0, 0, 0, 0, 0, 0), 1);
    cyc(0, 0, 0, 0, 32'h0, 1, e(32'h0, 0, 0, 0, 0, 0, 0, 0), 0);
    // Release again: clean boot with no residual flush.
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h0, 0, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h0, 1, 0, 0, 0, 0, 0, 0), 0);
    cyc(1, 0, 0, 0, 32'h0, 1, e(32'h4, 1, 0, 0, 0, 0, 0, 0), 0);

    // Bounded drain of the scoreboard.
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
